// File: rtl/rtc_calendar_pkg.sv
// rtc_pkg: shared definitions for the real-time clock/calendar.
//   field_e          - encoding of load_sel (which field a write targets)
//   BCD_*            - BCD terminal values used by the carry chain and validator
//   is_leap()        - Gregorian leap-year test on a 4-digit BCD year
//   days_in_month()  - month length in BCD for a BCD month/year
//   bcd_valid16()    - all four nibbles are decimal digits
//   bcd_inc8/16()    - decade-counter increment with digit ripple
package rtc_pkg;

   typedef enum logic [2:0] {
      FLD_SEC   = 3'd0,
      FLD_MIN   = 3'd1,
      FLD_HOUR  = 3'd2,
      FLD_DAY   = 3'd3,
      FLD_MONTH = 3'd4,
      FLD_YEAR  = 3'd5
   } field_e;

   localparam logic [7:0]  BCD_59   = 8'h59;
   localparam logic [7:0]  BCD_23   = 8'h23;
   localparam logic [7:0]  BCD_12   = 8'h12;
   localparam logic [15:0] BCD_9999 = 16'h9999;

   // Y = hi*100 + lo. Because 100 is a multiple of 4, Y%4 == lo%4 whenever
   // lo != 0; when lo == 0 the year is a century and leaps only if hi%4 == 0.
   function automatic logic is_leap(input logic [15:0] year);
      logic [6:0] lo;
      logic [6:0] hi;
      lo = 7'(year[7:4] * 4'd10 + year[3:0]);
      hi = 7'(year[15:12] * 4'd10 + year[11:8]);
      return ((lo != 7'd0) && (lo[1:0] == 2'b00)) ||
             ((lo == 7'd0) && (hi[1:0] == 2'b00));
   endfunction

   function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                               input logic [15:0] year);
      case (month)
         8'h02:                      return is_leap(year) ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
         default:                    return 8'h31;
      endcase
   endfunction

   function automatic logic bcd_valid16(input logic [15:0] v);
      return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) &&
             (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
   endfunction

   function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rtc_calendar_if.sv
// rtc_calendar_if: control/status bundle of the RTC.
//   mode      - 0 run, 1 set
//   load_en   - one-cycle field write strobe
//   load_sel  - target field (rtc_pkg::field_e)
//   load_data - right-aligned BCD value
//   load_err  - one-cycle pulse, write rejected
//   sec_tick  - one-cycle pulse, new second visible
//   time_bcd  - {hh, mm, ss}
//   date_bcd  - {YYYY, MM, DD}
//   seg       - 14 x 7-bit gfedcba patterns, digit 0 = seconds units
interface rtc_calendar_if;
   logic        mode;
   logic        load_en;
   logic [2:0]  load_sel;
   logic [15:0] load_data;
   logic        load_err;
   logic        sec_tick;
   logic [23:0] time_bcd;
   logic [31:0] date_bcd;
   logic [97:0] seg;

   modport master (output mode, load_en, load_sel, load_data,
                   input  load_err, sec_tick, time_bcd, date_bcd, seg);
   modport slave  (input  mode, load_en, load_sel, load_data,
                   output load_err, sec_tick, time_bcd, date_bcd, seg);
endinterface

// File: rtl/rtc_calendar_seg7_digit.sv
// seg7_digit: BCD digit to seven-segment pattern (gfedcba).
//   bcd_i - 4-bit digit; codes above 9 blank the display
//   seg_o - segment pattern, inverted when SEG_ACTIVE_LOW (common anode)
module seg7_digit #(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);
   logic [6:0] pat;

   always_comb begin
      case (bcd_i)
         4'd0:    pat = 7'h3F;
         4'd1:    pat = 7'h06;
         4'd2:    pat = 7'h5B;
         4'd3:    pat = 7'h4F;
         4'd4:    pat = 7'h66;
         4'd5:    pat = 7'h6D;
         4'd6:    pat = 7'h7D;
         4'd7:    pat = 7'h07;
         4'd8:    pat = 7'h7F;
         4'd9:    pat = 7'h6F;
         default: pat = 7'h00;
      endcase
   end

   assign seg_o = SEG_ACTIVE_LOW ? ~pat : pat;
endmodule

// File: rtl/rtc_calendar.sv
// rtc_calendar: BCD real-time clock/calendar with validated field writes.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - rtc_calendar_if.slave (mode/load inputs, time/date/seg outputs)
// A prescaler divides clk by TICK_DIV; each wrap advances ss->mm->hh->day->
// month->year. In set mode the prescaler is held at zero and writes through
// load_* are range-checked against the current calendar before being applied.
module rtc_calendar
   import rtc_pkg::*;
#(
   parameter int          TICK_DIV       = 50_000_000,
   parameter logic [15:0] RESET_YEAR     = 16'h2024,
   parameter logic [7:0]  RESET_MONTH    = 8'h01,
   parameter logic [7:0]  RESET_DAY      = 8'h01,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input logic            clk,
   input logic            rst_n,
   rtc_calendar_if.slave  bus
);
   localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
   logic [7:0]    day_q, day_d, mon_q, mon_d;
   logic [15:0]   year_q, year_d;
   logic          load_err_q, load_err_d, sec_tick_q, sec_tick_d;

   logic [7:0]    dim_cur, dim_new_mon, dim_new_year, load_lo;
   logic          load_hi_zero, load_ok;

   assign dim_cur      = days_in_month(mon_q, year_q);
   assign dim_new_mon  = days_in_month(bus.load_data[7:0], year_q);
   assign dim_new_year = days_in_month(mon_q, bus.load_data);
   assign load_lo      = bus.load_data[7:0];
   assign load_hi_zero = (bus.load_data[15:8] == 8'h00);

   // Load validator: valid BCD digits are ordered like binary, so range
   // checks are done directly on the BCD value.
   always_comb begin
      load_ok = bus.mode && bcd_valid16(bus.load_data);
      case (bus.load_sel)
         FLD_SEC, FLD_MIN: load_ok = load_ok && load_hi_zero && (load_lo <= BCD_59);
         FLD_HOUR:         load_ok = load_ok && load_hi_zero && (load_lo <= BCD_23);
         FLD_DAY:          load_ok = load_ok && load_hi_zero && (load_lo != 8'h00) &&
                                     (load_lo <= dim_cur);
         FLD_MONTH:        load_ok = load_ok && load_hi_zero && (load_lo != 8'h00) &&
                                     (load_lo <= BCD_12);
         FLD_YEAR:         load_ok = load_ok && (bus.load_data <= BCD_9999);
         default:          load_ok = 1'b0;
      endcase
   end

   always_comb begin
      presc_d    = presc_q;
      sec_d      = sec_q;
      min_d      = min_q;
      hour_d     = hour_q;
      day_d      = day_q;
      mon_d      = mon_q;
      year_d     = year_q;
      load_err_d = 1'b0;
      sec_tick_d = 1'b0;

      if (bus.mode) begin
         presc_d = '0;
      end else if (presc_q == PRESC_LAST) begin
         presc_d    = '0;
         sec_tick_d = 1'b1;
         // Decade counters with carry chain; each field wraps only when
         // every field below it wraps in the same second.
         if (sec_q != BCD_59) sec_d = bcd_inc8(sec_q);
         else begin
            sec_d = 8'h00;
            if (min_q != BCD_59) min_d = bcd_inc8(min_q);
            else begin
               min_d = 8'h00;
               if (hour_q != BCD_23) hour_d = bcd_inc8(hour_q);
               else begin
                  hour_d = 8'h00;
                  if (day_q != dim_cur) day_d = bcd_inc8(day_q);
                  else begin
                     day_d = 8'h01;
                     if (mon_q != BCD_12) mon_d = bcd_inc8(mon_q);
                     else begin
                        mon_d  = 8'h01;
                        year_d = (year_q == BCD_9999) ? 16'h0000 : bcd_inc16(year_q);
                     end
                  end
               end
            end
         end
      end else begin
         presc_d = presc_q + 1'b1;
      end

      // Accepted writes only happen in set mode, so they never coincide
      // with a tick. Month/year writes clamp the day to the new length.
      if (bus.load_en) begin
         if (!load_ok) load_err_d = 1'b1;
         else begin
            case (bus.load_sel)
               FLD_SEC: begin
                  sec_d   = load_lo;
                  presc_d = '0;
               end
               FLD_MIN:   min_d  = load_lo;
               FLD_HOUR:  hour_d = load_lo;
               FLD_DAY:   day_d  = load_lo;
               FLD_MONTH: begin
                  mon_d = load_lo;
                  if (day_q > dim_new_mon) day_d = dim_new_mon;
               end
               default: begin
                  year_d = bus.load_data;
                  if (day_q > dim_new_year) day_d = dim_new_year;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q    <= '0;
         sec_q      <= 8'h00;
         min_q      <= 8'h00;
         hour_q     <= 8'h00;
         day_q      <= RESET_DAY;
         mon_q      <= RESET_MONTH;
         year_q     <= RESET_YEAR;
         load_err_q <= 1'b0;
         sec_tick_q <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         sec_q      <= sec_d;
         min_q      <= min_d;
         hour_q     <= hour_d;
         day_q      <= day_d;
         mon_q      <= mon_d;
         year_q     <= year_d;
         load_err_q <= load_err_d;
         sec_tick_q <= sec_tick_d;
      end
   end

   assign bus.load_err = load_err_q;
   assign bus.sec_tick = sec_tick_q;
   assign bus.time_bcd = {hour_q, min_q, sec_q};
   assign bus.date_bcd = {year_q, mon_q, day_q};

   logic [55:0] digits_w;
   logic [97:0] seg_w;
   assign digits_w = {year_q, mon_q, day_q, hour_q, min_q, sec_q};

   for (genvar i = 0; i < 14; i++) begin : g_seg
      seg7_digit #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (
         .bcd_i (digits_w[4*i +: 4]),
         .seg_o (seg_w[7*i +: 7])
      );
   end

   assign bus.seg = seg_w;
endmodule

// File: doc/rtc_calendar.md
# rtc_calendar

Parametrised real-time clock/calendar that keeps hh:mm:ss and DD/MM/YYYY as BCD decade counters. It advances once per prescaled second, applies full Gregorian leap rules, and accepts validated per-field writes in set mode. It drives registered BCD digits and 14 seven-segment digit patterns to the board display pins.

## Interface
- TICK_DIV, 50_000_000: clk cycles per second (≥2).
- RESET_YEAR, 16'h2024: BCD year loaded on reset.
- RESET_MONTH, 8'h01: BCD month loaded on reset.
- RESET_DAY, 8'h01: BCD day loaded on reset.
- SEG_ACTIVE_LOW, 1: 1 = segment patterns inverted (common-anode).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = run, 1 = set (time frozen, loads accepted).
- load_en  in  1  one-cycle field write strobe.
- load_sel  in  3  0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year; 6–7 invalid.
- load_data  in  16  BCD value, right-aligned; unused upper nibbles must be 0.
- load_err  out  1  one-cycle pulse: write rejected.
- sec_tick  out  1  one-cycle pulse in the cycle the new second is visible.
- time_bcd  out  24  {hh, mm, ss}.
- date_bcd  out  32  {YYYY, MM, DD}.
- seg  out  98  14 × 7-bit patterns, digit 0 = ss units … digit 13 = YYYY thousands; bit order gfedcba.

## Operation
- Reset: time_bcd = 0, date_bcd = {RESET_YEAR, RESET_MONTH, RESET_DAY}, prescaler = 0, load_err = 0, sec_tick = 0.
- Run (mode=0): the prescaler counts 0…TICK_DIV−1. At terminal count it wraps to 0 and the clock advances one second.
- Carry chain: ss 59→00 carries to mm; mm 59→00 carries to hh; hh 23→00 carries to day; day at month length→01 carries to month; month 12→01 carries to year; year 9999→0000.
- Month length: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11. February is 29 if (Y%4==0 && Y%100!=0) || Y%400==0, else 28.
- Set (mode=1): the prescaler is held at 0 and no ticks occur.
- A load is accepted only in set mode, with all nibbles ≤9 and the value in range: sec/min 00–59, hour 00–23, month 01–12, day 01–month length (current month/year), year 0000–9999.
- Any other load (run mode, load_sel 6–7, bad BCD, out of range) pulses load_err the next cycle and leaves all state unchanged.
- If an accepted month or year write leaves day above the new month length, day is clamped to that length in the same update.
- Any accepted sec write also clears the prescaler.
- seg decode: digits 0–9 map to standard patterns, inverted when SEG_ACTIVE_LOW. Codes above 9 produce blank (all segments off, honouring polarity).

## Timing
- Terminal count at edge N: counters and sec_tick both update at that edge, so sec_tick is high during cycle N+1 only.
- Seconds period is exactly TICK_DIV cycles in run mode. After a set→run transition, the first tick occurs TICK_DIV cycles later.
- A load strobed at edge N is visible in time_bcd/date_bcd, or load_err is high, from edge N+1 on. load_err is one cycle wide.
- seg is a combinational function of the registered digits, with zero additional latency.
- Asserting rst_n mid-count returns every output to reset values immediately, independent of clk.

## Structure
- Package rtc_pkg holds the field enum for load_sel, BCD constants (59, 23, 12, 9999), the days_in_month(month, year) function and the leap function.
- Sub-module seg7_digit (4-bit BCD in, 7-bit pattern out, SEG_ACTIVE_LOW parameter) is instantiated 14 times.
- Top level contains the prescaler, the per-digit decade counters with carries, and the load validator.

## Test plan
- TICK_DIV=4, run from reset for 8 cycles: sec_tick high in cycles 4 and 8; time_bcd 24'h000001, then 24'h000002.
- Set 23:59:59 on 31/12/9999 in set mode, then run one tick: time_bcd=24'h000000, date_bcd=32'h0000_0101.
- Leap rules, ticking from 28/02 23:59:59: year 2024 gives 29/02; year 2100 gives 01/03; year 2000 gives 29/02.
- Loads: day=31 with month 04 gives load_err, state kept; in run mode, a valid sec load gives load_err; load_sel=6 gives load_err.
- Clamp: date 31/03/2023, load month=02, gives date_bcd=32'h2023_0228.
- rst_n pulsed low mid-second: outputs are 24'h000000 / 32'h2024_0101 without a clk edge; the first tick is TICK_DIV cycles after release.
